// File: rtl/uart_tx_sched_pkg.sv
// Shared definitions for the UART transmit scheduler and its frame serializer.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        GAP
    } uart_state_e;

    localparam int unsigned FRAME_BITS = 11;
    localparam int unsigned DATA_BITS  = 8;

    function automatic logic parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_tx_frm.sv
// Frame serializer: start, 8 data bits MSB first, XOR parity, stop, then GAP_BITS idle periods.
module uart_tx_frm
    import uart_pkg::*;
#(
    parameter int unsigned CLK_DIV  = 868,
    parameter int unsigned GAP_BITS = 1
) (
    input  logic       clk_sys,
    input  logic       rst_sys,
    input  logic       ld,
    input  logic [7:0] ld_data,
    output logic       uart_tx,
    output logic       rdy
);

    localparam int unsigned BW = $clog2(CLK_DIV);

    uart_state_e   state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic          par_q, par_d;
    logic          tick;
    logic          done;

    always_ff @(posedge clk_sys) begin
        if (rst_sys) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            par_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            par_q   <= par_d;
        end
    end

    assign tick = (baud_q == BW'(CLK_DIV - 1));
    // The final bit period also accepts a load so back-to-back frames need no idle cycle.
    assign done = tick && ((state_q == STOP && GAP_BITS == 0) || (state_q == GAP && bit_q == '0));
    assign rdy  = (state_q == IDLE) || done;

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        par_d   = par_q;
        if (state_q != IDLE) begin
            if (tick) begin
                baud_d = '0;
                case (state_q)
                    START: begin
                        state_d = DATA;
                        bit_d   = 3'(DATA_BITS - 1);
                    end
                    DATA: begin
                        if (bit_q == '0) state_d = PARITY;
                        else             bit_d   = bit_q - 3'd1;
                    end
                    PARITY: state_d = STOP;
                    STOP: begin
                        if (GAP_BITS == 0) begin
                            state_d = IDLE;
                        end else begin
                            state_d = GAP;
                            bit_d   = 3'(GAP_BITS - 1);
                        end
                    end
                    GAP: begin
                        if (bit_q == '0) state_d = IDLE;
                        else             bit_d   = bit_q - 3'd1;
                    end
                    default: state_d = IDLE;
                endcase
            end else begin
                baud_d = baud_q + BW'(1);
            end
        end
        if (ld && rdy) begin
            state_d = START;
            baud_d  = '0;
            sh_d    = ld_data;
            par_d   = parity(ld_data);
        end
    end

    always_comb begin
        uart_tx = 1'b1;
        case (state_q)
            START:   uart_tx = 1'b0;
            DATA:    uart_tx = sh_q[bit_q];
            PARITY:  uart_tx = par_q;
            default: uart_tx = 1'b1;
        endcase
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmit line among NREQ byte requesters.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned CLK_DIV  = 868,
    parameter int unsigned GAP_BITS = 1
) (
    input  logic              clk_sys,
    input  logic              rst_sys,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*8-1:0] req_data,
    output logic [NREQ-1:0]   gnt,
    output logic              uart_tx,
    output logic              busy,
    output logic [2:0]        cur_id
);

    localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [2:0]      last_q, last_d;
    logic [2:0]      cur_q, cur_d;
    logic            busy_q, busy_d;
    logic [2:0]      win;
    logic            found;
    int unsigned     idx;
    logic            rdy;
    logic            ld;
    logic [7:0]      ld_data;

    // Search last+1, last+2, ... modulo NREQ; the first pending requester wins.
    always_comb begin
        win   = last_q;
        found = 1'b0;
        idx   = 0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            idx = (32'(last_q) + i) % NREQ;
            if (!found && 1'(req >> idx)) begin
                found = 1'b1;
                win   = 3'(idx);
            end
        end
    end

    assign ld      = rdy & (|req);
    assign ld_data = 8'(req_data >> {win, 3'b000});

    always_comb begin
        gnt_d  = ld ? (ONE << win) : '0;
        last_d = ld ? win : last_q;
        cur_d  = ld ? win : cur_q;
        busy_d = rdy ? ld : busy_q;
    end

    always_ff @(posedge clk_sys) begin
        if (rst_sys) begin
            gnt_q  <= '0;
            last_q <= 3'(NREQ - 1);
            cur_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            gnt_q  <= gnt_d;
            last_q <= last_d;
            cur_q  <= cur_d;
            busy_q <= busy_d;
        end
    end

    uart_tx_frm #(
        .CLK_DIV  (CLK_DIV),
        .GAP_BITS (GAP_BITS)
    ) u_frm (
        .clk_sys (clk_sys),
        .rst_sys (rst_sys),
        .ld      (ld),
        .ld_data (ld_data),
        .uart_tx (uart_tx),
        .rdy     (rdy)
    );

    assign gnt    = gnt_q;
    assign cur_id = cur_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: frame-level reference model plus directed and random stimulus.
module tb_uart_tx_sched;

    localparam int NREQ      = 4;
    localparam int CLK_DIV   = 8;
    localparam int GAP_BITS  = 1;
    localparam int FRAME_CYC = (11 + GAP_BITS) * CLK_DIV;

    logic              clk_sys = 1'b0;
    logic              rst_sys;
    logic [NREQ-1:0]   req;
    logic [NREQ*8-1:0] req_data;
    logic [NREQ-1:0]   gnt;
    logic              uart_tx;
    logic              busy;
    logic [2:0]        cur_id;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    uart_tx_sched #(
        .NREQ     (NREQ),
        .CLK_DIV  (CLK_DIV),
        .GAP_BITS (GAP_BITS)
    ) dut (
        .clk_sys  (clk_sys),
        .rst_sys  (rst_sys),
        .req      (req),
        .req_data (req_data),
        .gnt      (gnt),
        .uart_tx  (uart_tx),
        .busy     (busy),
        .cur_id   (cur_id)
    );

    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: a frame is a list of line bits, each held CLK_DIV cycles after the grant.
    bit              m_active;
    int              m_t;
    int              m_last;
    int              m_cur;
    logic [NREQ-1:0] m_gnt;
    logic            m_bits [0:15];
    logic [7:0]      m_byte;

    initial begin
        m_active = 1'b0; m_t = 0; m_last = NREQ - 1; m_cur = 0; m_gnt = '0;
        for (int b = 0; b < 16; b++) m_bits[b] = 1'b1;
        forever begin
            @(posedge clk_sys);
            if (rst_sys) begin
                m_active = 1'b0; m_t = 0; m_last = NREQ - 1; m_cur = 0; m_gnt = '0;
            end else begin
                m_gnt = '0;
                if (m_active) begin
                    m_t++;
                    if (m_t == FRAME_CYC) m_active = 1'b0;
                end
                if (!m_active && req != '0) begin
                    for (int k = 1; k <= NREQ; k++) begin
                        int j;
                        j = (m_last + k) % NREQ;
                        if (req[j]) begin
                            m_byte    = req_data[8*j +: 8];
                            m_bits[0] = 1'b0;
                            for (int b = 0; b < 8; b++) m_bits[1+b] = m_byte[7-b];
                            m_bits[9] = ^m_byte;
                            for (int b = 10; b < 16; b++) m_bits[b] = 1'b1;
                            m_gnt[j] = 1'b1;
                            m_last   = j;
                            m_cur    = j;
                            m_active = 1'b1;
                            m_t      = 0;
                            break;
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk_sys) begin
        if (chk_en) begin
            check("gnt", gnt, m_gnt);
            check("busy", busy, m_active);
            check("cur_id", cur_id, m_cur);
            check("uart_tx", uart_tx, m_active ? m_bits[m_t / CLK_DIV] : 1'b1);
        end
    end

    int busy_run = 0;
    int busy_last = 0;
    always @(negedge clk_sys) begin
        if (busy === 1'b1) begin
            busy_run <= busy_run + 1;
        end else if (busy_run != 0) begin
            busy_last <= busy_run;
            busy_run  <= 0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic set_req(input int i, input logic [7:0] d);
        req_data[8*i +: 8] = d;
        req[i] = 1'b1;
    endtask

    task automatic wait_gnt(output int id, input int limit);
        id = -1;
        for (int k = 0; k < limit; k++) begin
            @(negedge clk_sys);
            if (gnt != '0) begin
                for (int i = 0; i < NREQ; i++) if (gnt[i]) id = i;
                return;
            end
        end
        n_chk++;
        n_err++;
        $display("FAIL wait_gnt: no grant within %0d cycles", limit);
    endtask

    task automatic wait_idle(input int limit);
        for (int k = 0; k < limit; k++) begin
            @(negedge clk_sys);
            if (busy === 1'b0) return;
        end
        n_chk++;
        n_err++;
        $display("FAIL wait_idle: busy still high after %0d cycles", limit);
    endtask

    // rs232-style decode, entered on the negedge of the grant cycle; samples each bit mid-period.
    task automatic sample_frame(output logic [10:0] v);
        v = '0;
        tick(CLK_DIV / 2);
        for (int b = 0; b < 11; b++) begin
            v = {v[9:0], uart_tx};
            if (b < 10) tick(CLK_DIV);
        end
    endtask

    initial begin
        int          id;
        int          prev;
        int          ng;
        logic [10:0] v;
        logic [7:0]  par_bytes [0:2];
        logic [10:0] par_exp   [0:2];

        par_bytes[0] = 8'h85; par_exp[0] = 11'b0_10000101_1_1;
        par_bytes[1] = 8'haa; par_exp[1] = 11'b0_10101010_0_1;
        par_bytes[2] = 8'h00; par_exp[2] = 11'b0_00000000_0_1;

        rst_sys = 1'b1; req = '0; req_data = '0;
        tick(2);
        chk_en = 1'b1;
        check("rst_uart_tx", uart_tx, 1);
        check("rst_gnt", gnt, 0);
        check("rst_busy", busy, 0);
        check("rst_cur_id", cur_id, 0);
        rst_sys = 1'b0;

        // Single byte: grant one cycle after the request, then the literal frame.
        set_req(0, 8'h11);
        tick(1);
        check("t1_gnt", gnt, 4'b0001);
        req[0] = 1'b0;
        sample_frame(v);
        check("t1_frame", v, 11'b0_00010001_0_1);
        tick(8);
        check("t1_gap_high", uart_tx, 1);
        wait_idle(40);
        tick(2);
        check("t1_busy_len", busy_last, FRAME_CYC);

        // Parity of three bytes through the decoder.
        for (int p = 0; p < 3; p++) begin
            set_req(1, par_bytes[p]);
            wait_gnt(id, 200);
            check("par_id", id, 1);
            req[1] = 1'b0;
            sample_frame(v);
            check("par_frame", v, par_exp[p]);
        end
        wait_idle(200);

        // Fairness with every requester pending continuously.
        rst_sys = 1'b1;
        tick(1);
        rst_sys = 1'b0;
        for (int i = 0; i < NREQ; i++) set_req(i, 8'(8'h10 + i));
        prev = 0;
        for (int g = 0; g < 8; g++) begin
            wait_gnt(id, 200);
            check("fair_id", id, g % NREQ);
            check("fair_cur_id", cur_id, g % NREQ);
            if (g > 0) check("fair_spacing", cyc - prev, FRAME_CYC);
            prev = cyc;
        end
        req = '0;
        wait_idle(200);

        // Late arrivals during a frame of requester 1.
        set_req(1, 8'h21);
        wait_gnt(id, 200);
        check("late_first", id, 1);
        req[1] = 1'b0;
        tick(30);
        set_req(2, 8'h32);
        tick(1);
        set_req(0, 8'h40);
        wait_gnt(id, 200);
        check("late_second", id, 2);
        req[2] = 1'b0;
        wait_gnt(id, 200);
        check("late_third", id, 0);
        req[0] = 1'b0;

        // Withdrawn request during a busy frame.
        tick(10);
        set_req(3, 8'h77);
        tick(5);
        req[3] = 1'b0;
        ng = 0;
        for (int k = 0; k < 150; k++) begin
            tick(1);
            if (gnt != '0) ng++;
        end
        check("wd_no_gnt", ng, 0);
        check("wd_line_high", uart_tx, 1);
        check("wd_not_busy", busy, 0);

        // Reset during the data bits.
        set_req(1, 8'hc3);
        wait_gnt(id, 200);
        check("rstmid_id", id, 1);
        req[1] = 1'b0;
        tick(35);
        rst_sys = 1'b1;
        tick(1);
        check("rstmid_uart_tx", uart_tx, 1);
        check("rstmid_busy", busy, 0);
        check("rstmid_gnt", gnt, 0);
        check("rstmid_cur_id", cur_id, 0);
        rst_sys = 1'b0;
        set_req(2, 8'h5a);
        tick(1);
        check("rstmid_regnt", gnt, 4'b0100);
        req[2] = 1'b0;
        sample_frame(v);
        check("rstmid_frame", v, 11'b0_01011010_0_1);
        wait_idle(200);

        // Random traffic: requesters hold until granted, sometimes re-queue or withdraw.
        for (int n = 0; n < 4000; n++) begin
            rst_sys = ($urandom_range(0, 1499) == 0);
            for (int i = 0; i < NREQ; i++) begin
                if (req[i]) begin
                    if (gnt[i]) begin
                        if ($urandom_range(0, 3) != 0) req[i] = 1'b0;
                    end else if ($urandom_range(0, 299) == 0) begin
                        req[i] = 1'b0;
                    end
                end else if ($urandom_range(0, 59) == 0) begin
                    set_req(i, 8'($urandom));
                end
            end
            tick(1);
        end
        req = '0;
        rst_sys = 1'b0;
        wait_idle(200);
        tick(3);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Shares one UART transmit line among NREQ byte requesters with round-robin arbitration, and serializes each granted byte.
- Frame format matches the board link: 1 start bit (0), 8 data bits MSB first, 1 parity bit equal to XOR of the data byte, 1 stop bit (1), then GAP_BITS idle bits.
- Sits between on-chip status/command sources and the uart_tx pin. Drives the same line protocol the rs232 bench model produces.

Parameters:
- NREQ, 4, number of requesters (2..8).
- CLK_DIV, 868, clk_sys cycles per bit period (minimum 2).
- GAP_BITS, 1, idle bit periods after each stop bit (0..4).

Ports:
- clk_sys  input  1  system clock, all logic on rising edge.
- rst_sys  input  1  synchronous, active-high reset.
- req  input  NREQ  per-requester byte request; held high until gnt.
- req_data  input  NREQ*8  byte for requester i at bits [8i+7:8i]; stable while req[i] is high.
- gnt  output  NREQ  one-hot, one-cycle pulse; the byte for that requester has been captured.
- uart_tx  output  1  serial line, idle high.
- busy  output  1  high from grant through the end of the gap.
- cur_id  output  3  index of the requester currently being sent; holds its last value when idle.

Behaviour:
- Reset values: uart_tx=1, gnt=0, busy=0, cur_id=0, state IDLE, round-robin pointer last=NREQ-1 (so requester 0 wins first).
- States: IDLE, START, DATA, PARITY, STOP, GAP.
  - GAP is skipped when GAP_BITS=0.
  - Each bit state lasts exactly CLK_DIV cycles, counted by baud_cnt from 0 to CLK_DIV-1.
- IDLE: on a clock edge with req != 0:
  - Winner is the first set bit searching last+1, last+2, ... modulo NREQ.
  - Registered at that edge: gnt[winner]=1 for one cycle, shift register = req_data[winner], parity = ^req_data[winner], cur_id=winner, last=winner, busy=1, uart_tx=0, state START.
  - Latency: req sampled at edge k, so gnt and the start bit are both visible after edge k.
- START -> DATA.
- DATA: 8 bit periods, bit_cnt 7 down to 0, uart_tx = data[bit_cnt] (MSB first) -> PARITY.
- PARITY: uart_tx = parity -> STOP.
- STOP: uart_tx = 1 -> GAP, or IDLE when GAP_BITS=0.
- GAP: uart_tx = 1 for GAP_BITS periods -> IDLE. busy clears on the IDLE entry edge.
- Frame length is (11+GAP_BITS)*CLK_DIV cycles from gnt to the next possible gnt.
- The next grant can occur on the first IDLE cycle, i.e. back-to-back with no extra idle cycle.
- Requests during a frame are not granted. They are evaluated on IDLE entry with the updated pointer.
- A requester that keeps req high after gnt is queued for another byte. Under round-robin it is served again only after the other pending requesters.
- Withdrawing req before it is granted is legal. No gnt is issued and no state is kept.
- Grant and new request in the same cycle: the request is seen at the next evaluation only. gnt never pulses twice for one frame.
- gnt is always one-hot or zero.
- rst_sys mid-frame: the next edge forces the reset values. uart_tx returns high immediately, the partial frame is abandoned, and the pointer resets.
- req_data is read only at the grant edge. Changes afterwards do not affect the frame in flight.

Decomposition:
- Shared package uart_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP, GAP);
  - FRAME_BITS=11;
  - DATA_BITS=8;
  - parity function (XOR reduce).
- Sub-module uart_tx_frm: serializer with ports clk_sys, rst_sys, ld (1-cycle load), ld_data[7:0], uart_tx and rdy.
  - It owns the baud counter, bit counter and state machine.
  - rdy is high in IDLE.
- uart_tx_sched keeps the round-robin arbiter, gnt/cur_id/busy, and drives ld = (rdy & |req).

Test Plan:
- Single byte, CLK_DIV=8, GAP_BITS=1: req[0]=1 with 0x11.
  - Expect gnt[0] for 1 cycle, then per 8-cycle period: 0,0,0,0,1,0,0,0,1,0,1, then 8 cycles high.
  - busy is high for 96 cycles.
- Parity check: 0x85 -> data 1,0,0,0,0,1,0,1 and parity 1. 0xaa -> parity 0. 0x00 -> parity 0.
  - Bench rs232-style decoder checks all three.
- Fairness: req=4'b1111 held continuously with bytes 0x10..0x13.
  - Grant order 0,1,2,3,0,...; cur_id tracks the grants; consecutive gnt pulses are exactly 96 cycles apart.
- Late arrival: req[2] asserted mid-frame of req[1]; req[0] asserted one cycle later.
  - Next grant goes to 2 (pointer after 1); 0 follows.
- Withdrawal: req[3] pulsed for 5 cycles during a busy frame, then dropped.
  - No gnt[3] and no extra frame; line stays high after the gap.
- Reset mid-frame: rst_sys for 1 cycle during DATA bit 4.
  - Next cycle uart_tx=1, busy=0, gnt=0.
  - A subsequent req[2] alone is granted immediately with a full, correct frame.
